// File: rtl/vm_pkg.sv
// Shared constants for the change dispenser: denominations, inventory select
// codes, FSM state encoding and default hopper timeout.
package vm_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 1000;
    localparam int unsigned NUM_DENOM       = 5;

    localparam logic [2:0] SEL_50 = 3'd0;
    localparam logic [2:0] SEL_20 = 3'd1;
    localparam logic [2:0] SEL_10 = 3'd2;
    localparam logic [2:0] SEL_5  = 3'd3;
    localparam logic [2:0] SEL_1  = 3'd4;

    localparam logic [7:0] DEN_50 = 8'd50;
    localparam logic [7:0] DEN_20 = 8'd20;
    localparam logic [7:0] DEN_10 = 8'd10;
    localparam logic [7:0] DEN_5  = 8'd5;
    localparam logic [7:0] DEN_1  = 8'd1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    function automatic logic [7:0] denom_value(input logic [2:0] sel);
        case (sel)
            SEL_50:  return DEN_50;
            SEL_20:  return DEN_20;
            SEL_10:  return DEN_10;
            SEL_5:   return DEN_5;
            SEL_1:   return DEN_1;
            default: return 8'd0;
        endcase
    endfunction

    // hopper_req bit 4 is the 50-yuan chute, bit 0 the 1-yuan chute
    function automatic logic [4:0] denom_onehot(input logic [2:0] sel);
        return 5'b10000 >> sel;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Control, inventory-load and hopper handshake bundle for change_dispense_ctrl.
interface change_dispense_ctrl_if #(
    parameter int unsigned INV_W = 8
);
    logic             start;
    logic [7:0]       change_amt;
    logic             inv_load;
    logic [2:0]       inv_sel;
    logic [INV_W-1:0] inv_val;
    logic             err_clr;
    logic             hopper_ack;
    logic [4:0]       hopper_req;
    logic             busy;
    logic             done;
    logic [7:0]       remain;
    logic             err_short;
    logic             err_timeout;

    modport master (
        output start, change_amt, inv_load, inv_sel, inv_val, err_clr, hopper_ack,
        input  hopper_req, busy, done, remain, err_short, err_timeout
    );

    modport slave (
        input  start, change_amt, inv_load, inv_sel, inv_val, err_clr, hopper_ack,
        output hopper_req, busy, done, remain, err_short, err_timeout
    );
endinterface

// File: rtl/dispense_timer.sv
// Loadable down-counter with synchronous clear; expired is high while the count is zero.
module dispense_timer #(
    parameter int unsigned CW = 10
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          load,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          expired
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout controller: greedy denomination selection from per-coin inventory,
// one-hot hopper request/ack handshake with timeout and shortage error reporting.
module change_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned INV_W       = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    change_dispense_ctrl_if.slave bus
);
    localparam int unsigned      TCW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0]   TMR_RELOAD = TCW'(TIMEOUT_CYC - 1);
    localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);

    logic [2:0]       state_q, state_d;
    logic [7:0]       remain_q;
    logic [2:0]       sel_q;
    logic [INV_W-1:0] inv_q [NUM_DENOM];
    logic [4:0]       hopper_req_q;
    logic             busy_q, done_q, err_short_q, err_timeout_q;
    logic             pick_found;
    logic [2:0]       pick_sel;
    logic             tmr_load, tmr_clr, tmr_en, tmr_expired;

    // Largest eligible denomination wins: scan from 50 down to 1
    always_comb begin
        pick_found = 1'b0;
        pick_sel   = '0;
        for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            if (!pick_found && (denom_value(3'(i)) <= remain_q) && (inv_q[3'(i)] != '0)) begin
                pick_found = 1'b1;
                pick_sel   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_SELECT;
            ST_SELECT: begin
                if (remain_q == '0)  state_d = ST_DONE;
                else if (pick_found) state_d = ST_REQ;
                else                 state_d = ST_ERROR;
            end
            ST_REQ: begin
                if (bus.hopper_ack)   state_d = ST_RELEASE;
                else if (tmr_expired) state_d = ST_ERROR;
            end
            ST_RELEASE: if (!bus.hopper_ack) state_d = ST_SELECT;
            ST_DONE:    state_d = ST_IDLE;
            ST_ERROR:   if (bus.err_clr) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign tmr_load = (state_q == ST_SELECT) && (state_d == ST_REQ);
    assign tmr_clr  = (state_q == ST_REQ) && (state_d != ST_REQ);
    assign tmr_en   = (state_q == ST_REQ);

    dispense_timer #(.CW(TCW)) u_timer (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .load     (tmr_load),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .load_val (TMR_RELOAD),
        .expired  (tmr_expired)
    );

    // hopper_req and done are registered from the current state, so they trail
    // entry into REQ/DONE by one edge; req still drops on the ack/timeout edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            remain_q      <= '0;
            sel_q         <= '0;
            hopper_req_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_short_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_DENOM; i++) inv_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_q == ST_DONE);
            hopper_req_q <= ((state_q == ST_REQ) && (state_d == ST_REQ)) ? denom_onehot(sel_q) : '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        remain_q <= bus.change_amt;
                    end else if (bus.inv_load && (bus.inv_sel <= SEL_1)) begin
                        inv_q[bus.inv_sel] <= bus.inv_val;
                    end
                end
                ST_SELECT: begin
                    sel_q <= pick_sel;
                    if ((remain_q != '0) && !pick_found) err_short_q <= 1'b1;
                end
                ST_REQ: begin
                    if (bus.hopper_ack) begin
                        remain_q     <= remain_q - denom_value(sel_q);
                        inv_q[sel_q] <= inv_q[sel_q] - INV_ONE;
                    end else if (tmr_expired) begin
                        err_timeout_q <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (bus.err_clr) begin
                        err_short_q   <= 1'b0;
                        err_timeout_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hopper_req  = hopper_req_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.remain      = remain_q;
    assign bus.err_short   = err_short_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, max cycles REQ waits for hopper_ack before fault.
REQ-002 Parameter INV_W, default 8, width of each per-denomination coin inventory counter.
REQ-003 sys_clk  input  1  rising-edge system clock.
REQ-004 sys_rst_n  input  1  reset: asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse to begin payout of change_amt.
REQ-006 change_amt  input  8  change to pay, in yuan, sampled only when start is accepted.
REQ-007 inv_load  input  1  write inv_val into the inventory counter selected by inv_sel.
REQ-008 inv_sel  input  3  0=50, 1=20, 2=10, 3=5, 4=1; values 5-7 are ignored.
REQ-009 inv_val  input  INV_W  inventory load value.
REQ-010 err_clr  input  1  clears error flags and returns to IDLE.
REQ-011 hopper_ack  input  1  hopper level handshake: high once a coin/note has been ejected.
REQ-012 hopper_req  output  5  one-hot eject request, bit4=50, bit3=20, bit2=10, bit1=5, bit0=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when remain reaches 0.
REQ-015 remain  output  8  change still owed.
REQ-016 err_short  output  1  sticky: inventory cannot make exact change.
REQ-017 err_timeout  output  1  sticky: hopper_ack did not arrive within TIMEOUT_CYC.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, REQ, RELEASE, DONE, ERROR; all outputs registered.
REQ-019 IDLE: start latches change_amt into remain, next state SELECT; start outside IDLE is ignored.
REQ-020 SELECT: greedy pick of the largest denomination d with d<=remain and inv[d]>0, next state REQ.
REQ-021 SELECT with remain==0: go to DONE; with remain>0 and no eligible d: set err_short, go to ERROR.
REQ-022 REQ: drive hopper_req one-hot for d, held stable until hopper_ack=1.
REQ-023 On hopper_ack=1 in REQ: remain-=d, inv[d]-=1, hopper_req=0, next state RELEASE, all in the same edge.
REQ-024 RELEASE: wait for hopper_ack=0, then go to SELECT.
REQ-025 Latency: start accepted at edge N gives hopper_req valid after edge N+2; each coin costs at least 3 cycles (REQ, RELEASE, SELECT).
REQ-026 Timeout counter clears on REQ entry; at TIMEOUT_CYC cycles in REQ without ack: err_timeout=1, hopper_req=0, go to ERROR, remain and inventory unchanged.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 start with change_amt=0: SELECT, then DONE; no hopper_req is issued.
REQ-029 ERROR: hold flags and remain; only err_clr (or reset) returns to IDLE; err_clr clears both flags.
REQ-030 err_clr outside ERROR has no effect.
REQ-031 inv_load is honoured only in IDLE and only when start=0; if both are high, start wins and the load is dropped.
REQ-032 Inventory SHALL never underflow: decrement only follows a selection that required inv[d]>0.
REQ-033 remain arithmetic is 8-bit unsigned; subtraction never wraps because d<=remain.
REQ-034 hopper_ack high on REQ entry counts as an immediate ack.

Reset
REQ-035 Async reset SHALL set: state=IDLE, hopper_req=0, busy=0, done=0, remain=0, err_short=0, err_timeout=0, all inventory counters=0, timeout counter=0.
REQ-036 Reset mid-payout SHALL drop hopper_req the same instant; ejected coins are not restored.

Structure
REQ-037 Shared package vm_pkg holds the denomination constants (50, 20, 10, 5, 1), the inv_sel encoding, the FSM state encoding and the TIMEOUT_CYC default.
REQ-038 Single sub-module dispense_timer: loadable down-counter with clear and expiry flag, used for REQ-026.

Verification
REQ-039 Load inv={50:1, 20:2, 10:2, 5:2, 1:5}, start amt=87, ack after 2 cycles each -> req sequence 50, 20, 10, 5, 1, 1; done pulse; remain=0; inv 20 becomes 1.
REQ-040 Inventory has only 1s=3, amt=5 -> three 1-yuan ejects, then err_short=1, remain=2, busy=1.
REQ-041 TIMEOUT_CYC=8, amt=10, never ack -> err_timeout after 8 REQ cycles, hopper_req=0, remain=10; err_clr -> IDLE.
REQ-042 amt=0 -> done at N+2, hopper_req never asserts; a second start during busy is ignored.
REQ-043 Assert sys_rst_n low while hopper_req=0b00100 -> all outputs zero immediately; inventory zero.
REQ-044 inv_load with start in the same cycle -> load dropped, payout uses the old inventory.
